// File: rtl/redun_mont_pkg.sv
// rtl/redun_mont_pkg.sv - shared types and multiplier control encodings for the Montgomery datapath
package redun_mont_pkg;

   localparam int DIGIT_W = 17;

   typedef logic [DIGIT_W-1:0] digit_t;

   typedef enum logic [2:0] {
      IDLE,
      SQ,
      LO,
      HI,
      DONE
   } state_t;

   localparam logic [2:0] CTL_NONE = 3'b000;
   localparam logic [2:0] CTL_SQ   = 3'b001;
   localparam logic [2:0] CTL_LO   = 3'b010;
   localparam logic [2:0] CTL_HI   = 3'b100;

endpackage

// File: rtl/mont_sq_sequencer.sv
// rtl/mont_sq_sequencer.sv - iterated Montgomery squaring controller driving a 3-mode redundant multiplier
module mont_sq_sequencer
   import redun_mont_pkg::*;
#(
   parameter int NUM_ELEMENTS = 33,
   parameter int DSP_BIT_LEN  = 17,
   parameter int WORD_LEN     = 16,
   parameter int MUL_LAT      = 1,
   parameter int ITER_W       = 32
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst,
   input  logic                                  i_valid,
   output logic                                  o_ready,
   input  logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]   i_sq,
   input  logic [ITER_W-1:0]                     i_iter,
   input  logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]   i_modulus,
   input  logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]   i_mont_fac,
   output logic [2:0]                            o_mul_ctl,
   output logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]   o_mul_a,
   output logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]   o_mul_b,
   output logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]   o_mul_add,
   input  logic [2*NUM_ELEMENTS*DSP_BIT_LEN-1:0] i_mul_dat,
   output logic                                  o_valid,
   input  logic                                  i_ready,
   output logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0]   o_dat
);

   localparam int NW    = NUM_ELEMENTS * DSP_BIT_LEN;
   localparam int CNT_W = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
   localparam logic [CNT_W-1:0] SUB_LAST = CNT_W'(MUL_LAT);

   // Redundant digits need at least one headroom bit above the radix.
   if (WORD_LEN >= DSP_BIT_LEN || WORD_LEN < 1) begin : g_bad_radix
      $error("mont_sq_sequencer: WORD_LEN must be in 1..DSP_BIT_LEN-1");
   end

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    sub_q, sub_d;
   logic [ITER_W-1:0]   iter_q;
   logic [2*NW-1:0]     t_q;
   logic [NW-1:0]       m_q;
   logic [NW-1:0]       cur_q;
   logic [NW-1:0]       dat_q;
   logic                accept;
   logic                op_last;
   logic                last_iter;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         sub_q   <= '0;
         iter_q  <= '0;
         t_q     <= '0;
         m_q     <= '0;
         cur_q   <= '0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         sub_q   <= sub_d;
         if (accept) begin
            cur_q  <= i_sq;
            iter_q <= i_iter;
            if (i_iter == '0) begin
               dat_q <= i_sq;
            end
         end
         // The multiplier result is only trusted on the last cycle of each op state.
         if (op_last) begin
            case (state_q)
               SQ: t_q <= i_mul_dat;
               LO: m_q <= i_mul_dat[NW-1:0];
               HI: begin
                  cur_q  <= i_mul_dat[2*NW-1:NW];
                  iter_q <= iter_q - 1'b1;
                  if (last_iter) begin
                     dat_q <= i_mul_dat[2*NW-1:NW];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      sub_d     = '0;
      accept    = 1'b0;
      o_ready   = 1'b0;
      o_valid   = 1'b0;
      o_mul_ctl = CTL_NONE;
      o_mul_a   = '0;
      o_mul_b   = '0;
      o_mul_add = '0;
      op_last   = (sub_q == SUB_LAST);
      last_iter = (iter_q == ITER_W'(1));
      case (state_q)
         IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
               accept  = 1'b1;
               state_d = (i_iter == '0) ? DONE : SQ;
            end
         end
         SQ: begin
            o_mul_ctl = CTL_SQ;
            o_mul_a   = cur_q;
            o_mul_b   = cur_q;
            if (op_last) state_d = LO;
            else         sub_d   = sub_q + 1'b1;
         end
         LO: begin
            o_mul_ctl = CTL_LO;
            o_mul_a   = t_q[NW-1:0];
            o_mul_b   = i_mont_fac;
            if (op_last) state_d = HI;
            else         sub_d   = sub_q + 1'b1;
         end
         HI: begin
            o_mul_ctl = CTL_HI;
            o_mul_a   = m_q;
            o_mul_b   = i_modulus;
            o_mul_add = t_q[2*NW-1:NW];
            if (op_last) state_d = last_iter ? DONE : SQ;
            else         sub_d   = sub_q + 1'b1;
         end
         DONE: begin
            o_valid = 1'b1;
            if (i_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_dat = dat_q;

endmodule
